pc_sequencer: RTL and testbench

//  Parametrised program counter for the fetch stage. Generates the instruction address bus.

---
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with sequential step, absolute jump,
// PC-relative branch, stall, halt/resume and an optional return-address stack.
// Optional feature macro: PC_RAS_EN (adds the call/ret return-address stack).
//
// state  | meaning
// -------+------------------------------------------------------------
// S_BOOT | first cycle after reset release; pc = RESET_VEC, not valid
// S_RUN  | fetching; pc advances by command priority when en=1
// S_HALT | pc frozen and not valid; waits for resume with en=1
module pc_sequencer #(
    parameter int                 ADDR_W    = 11,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int                 STEP      = 1,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_off,
    input  logic              call,
    input  logic              ret,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              halted,
    output logic              ras_err
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    state_t            state;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_br;

    // Plain modular adds: truncation to ADDR_W gives wrap in both directions,
    // and adding the two's-complement offset is the same as a signed add.
    assign pc_inc = pc + STEP_V;
    assign pc_br  = pc + br_off;

`ifdef PC_RAS_EN
    localparam int                PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]    FULL  = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W:0]    depth;
    logic              cmd_live;
    logic              do_push;

    // Commands only take effect in RUN with en=1 and no halt request; ret
    // outranks call, so a push happens only when ret is absent.
    assign cmd_live = en && (state == S_RUN) && !halt_req;
    assign do_push  = cmd_live && !ret && call;
    assign top_ptr  = wr_ptr - 1'b1;

    // Stack storage; contents need no reset since depth tracks validity.
    // When full, wr_ptr wraps onto the oldest entry, which is overwritten.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[wr_ptr] <= pc_inc;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ret ^ (RAS_DEPTH > 1);
`endif

    // Sequencer FSM: next pc selection, mode tracking and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            pc       <= RESET_VEC;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
            ras_err  <= 1'b0;
`ifdef PC_RAS_EN
            wr_ptr   <= '0;
            depth    <= '0;
`endif
        end else if (!en) begin
            ras_err <= 1'b0;
        end else begin
            ras_err <= 1'b0;
            case (state)
                S_BOOT: begin
                    state    <= S_RUN;
                    pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (halt_req) begin
                        state    <= S_HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
`ifdef PC_RAS_EN
                    else if (ret) begin
                        if (depth == '0) begin
                            pc      <= pc_inc;
                            ras_err <= 1'b1;
                        end else begin
                            pc     <= stack[top_ptr];
                            wr_ptr <= top_ptr;
                            depth  <= depth - 1'b1;
                        end
                    end else if (call) begin
                        pc     <= jmp_addr;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (depth == FULL) begin
                            ras_err <= 1'b1;
                        end else begin
                            depth <= depth + 1'b1;
                        end
                    end
`else
                    else if (call) begin
                        pc <= jmp_addr;
                    end
`endif
                    else if (jmp) begin
                        pc <= jmp_addr;
                    end else if (br) begin
                        pc <= pc_br;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state    <= S_RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer (ADDR_W=11, RESET_VEC=0x010, STEP=1, RAS_DEPTH=4).
// Directed scenarios plus a randomized run checked against a queue-based model.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        jmp = 1'b0;
    logic [10:0] jmp_addr = '0;
    logic        br = 1'b0;
    logic [10:0] br_off = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [10:0] pc;
    logic        pc_valid;
    logic        halted;
    logic        ras_err;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_pc;
    bit m_boot;
    bit m_halt;
    bit m_err;
    int m_stack[$];

    pc_sequencer #(
        .ADDR_W(11),
        .RESET_VEC(11'h010),
        .STEP(1),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .jmp(jmp),
        .jmp_addr(jmp_addr),
        .br(br),
        .br_off(br_off),
        .call(call),
        .ret(ret),
        .halt_req(halt_req),
        .resume(resume),
        .pc(pc),
        .pc_valid(pc_valid),
        .halted(halted),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc   = 'h010;
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_err  = 1'b0;
        m_stack.delete();
    endtask

    // One clock of the intended behaviour, from the current inputs.
    task automatic model_step();
        int off;
        m_err = 1'b0;
        if (!en) return;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (resume) m_halt = 1'b0;
        end else if (halt_req) begin
            m_halt = 1'b1;
        end else if (RAS_ON && ret) begin
            if (m_stack.size() == 0) begin
                m_pc  = (m_pc + 1) % 2048;
                m_err = 1'b1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (call) begin
            if (RAS_ON) begin
                if (m_stack.size() == 4) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_stack.push_back((m_pc + 1) % 2048);
            end
            m_pc = int'(jmp_addr);
        end else if (jmp) begin
            m_pc = int'(jmp_addr);
        end else if (br) begin
            off  = br_off[10] ? int'(br_off) - 2048 : int'(br_off);
            m_pc = (m_pc + off + 2048) % 2048;
        end else begin
            m_pc = (m_pc + 1) % 2048;
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; jmp = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic goto_addr(input logic [10:0] a);
        idle();
        jmp = 1'b1; jmp_addr = a;
        tick();
        jmp = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pc !== 11'h010) begin n_err++; $display("FAIL reset_pc: got %h want 010", pc); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        n_cmp++; if (halted !== 1'b0 || ras_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got halted=%b ras_err=%b want 0/0", halted, ras_err); end
        rst_n = 1'b1;
        model_reset();
        #2;
        n_cmp++; if (pc !== 11'h010 || pc_valid !== 1'b0) begin n_err++; $display("FAIL boot_hold: got %h/%b want 010/0", pc, pc_valid); end
        tick();
        n_cmp++; if (pc !== 11'h010 || pc_valid !== 1'b1) begin n_err++; $display("FAIL boot_run: got %h/%b want 010/1", pc, pc_valid); end
        tick();
        n_cmp++; if (pc !== 11'h011 || pc_valid !== 1'b1) begin n_err++; $display("FAIL seq_1: got %h/%b want 011/1", pc, pc_valid); end
        tick();
        n_cmp++; if (pc !== 11'h012 || pc_valid !== 1'b1) begin n_err++; $display("FAIL seq_2: got %h/%b want 012/1", pc, pc_valid); end
    endtask

    task automatic test_wrap_branch();
        goto_addr(11'h7FE);
        n_cmp++; if (pc !== 11'h7FE) begin n_err++; $display("FAIL jmp_7fe: got %h want 7fe", pc); end
        tick();
        n_cmp++; if (pc !== 11'h7FF) begin n_err++; $display("FAIL inc_7ff: got %h want 7ff", pc); end
        tick();
        n_cmp++; if (pc !== 11'h000) begin n_err++; $display("FAIL wrap_000: got %h want 000", pc); end
        goto_addr(11'h005);
        br = 1'b1; br_off = 11'h7FA;
        tick();
        n_cmp++; if (pc !== 11'h7FF) begin n_err++; $display("FAIL br_back_wrap: got %h want 7ff", pc); end
        br_off = 11'h003;
        tick();
        n_cmp++; if (pc !== 11'h002) begin n_err++; $display("FAIL br_fwd_wrap: got %h want 002", pc); end
        br = 1'b0;
    endtask

    task automatic test_priority_stall();
        idle();
        jmp = 1'b1; br = 1'b1; jmp_addr = 11'h100; br_off = 11'h050;
        tick();
        n_cmp++; if (pc !== 11'h100) begin n_err++; $display("FAIL jmp_over_br: got %h want 100", pc); end
        br = 1'b0; en = 1'b0; jmp_addr = 11'h3AB;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pc !== 11'h100 || ras_err !== 1'b0 || pc_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_%0d: got pc=%h err=%b valid=%b want 100/0/1", i, pc, ras_err, pc_valid);
            end
        end
        idle();
        tick();
        n_cmp++; if (pc !== 11'h101) begin n_err++; $display("FAIL stall_release: got %h want 101", pc); end
    endtask

    task automatic test_halt();
        goto_addr(11'h020);
        halt_req = 1'b1; jmp = 1'b1; jmp_addr = 11'h333;
        tick();
        n_cmp++; if (pc !== 11'h020 || halted !== 1'b1 || pc_valid !== 1'b0) begin
            n_err++; $display("FAIL halt_enter: got pc=%h halted=%b valid=%b want 020/1/0", pc, halted, pc_valid);
        end
        halt_req = 1'b0;
        tick();
        n_cmp++; if (pc !== 11'h020 || halted !== 1'b1) begin n_err++; $display("FAIL halt_jmp_ignored: got pc=%h halted=%b want 020/1", pc, halted); end
        jmp = 1'b0; resume = 1'b1; en = 1'b0;
        tick();
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL resume_stalled: got halted=%b want 1", halted); end
        en = 1'b1;
        tick();
        n_cmp++; if (pc !== 11'h020 || pc_valid !== 1'b1 || halted !== 1'b0) begin
            n_err++; $display("FAIL resume: got pc=%h valid=%b halted=%b want 020/1/0", pc, pc_valid, halted);
        end
        idle();
        tick();
        n_cmp++; if (pc !== 11'h021) begin n_err++; $display("FAIL after_resume: got %h want 021", pc); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [10:0] want;
        goto_addr(11'h030);
        call = 1'b1; jmp_addr = 11'h200;
        tick();
        n_cmp++; if (pc !== 11'h200) begin n_err++; $display("FAIL call: got %h want 200", pc); end
        call = 1'b0; ret = 1'b1;
        tick();
        n_cmp++; if (pc !== 11'h031 || ras_err !== 1'b0) begin n_err++; $display("FAIL ret: got %h/%b want 031/0", pc, ras_err); end
        ret = 1'b0;
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; jmp_addr = 11'(11'h300 + i);
            tick();
            n_cmp++; if (pc !== 11'(11'h300 + i) || ras_err !== (i == 4)) begin
                n_err++; $display("FAIL nest_call_%0d: got pc=%h err=%b want %h/%b", i, pc, ras_err, 11'(11'h300 + i), (i == 4));
            end
        end
        call = 1'b0; ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            want = 11'(11'h304 - i);
            n_cmp++; if (pc !== want || ras_err !== 1'b0) begin
                n_err++; $display("FAIL nest_ret_%0d: got pc=%h err=%b want %h/0", i, pc, ras_err, want);
            end
        end
        tick();
        n_cmp++; if (pc !== 11'h302 || ras_err !== 1'b1) begin n_err++; $display("FAIL ret_empty: got %h/%b want 302/1", pc, ras_err); end
        idle();
        tick();
        n_cmp++; if (pc !== 11'h303 || ras_err !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %h/%b want 303/0", pc, ras_err); end
    endtask
`else
    task automatic test_ras();
        goto_addr(11'h030);
        call = 1'b1; jmp_addr = 11'h200;
        tick();
        n_cmp++; if (pc !== 11'h200 || ras_err !== 1'b0) begin n_err++; $display("FAIL call_as_jmp: got %h/%b want 200/0", pc, ras_err); end
        call = 1'b0; ret = 1'b1;
        tick();
        n_cmp++; if (pc !== 11'h201 || ras_err !== 1'b0) begin n_err++; $display("FAIL ret_ignored: got %h/%b want 201/0", pc, ras_err); end
        br = 1'b1; br_off = 11'h004;
        tick();
        n_cmp++; if (pc !== 11'h205 || ras_err !== 1'b0) begin n_err++; $display("FAIL ret_falls_to_br: got %h/%b want 205/0", pc, ras_err); end
        idle();
    endtask
`endif

    task automatic test_async_reset();
        idle();
        call = 1'b1; jmp_addr = 11'h155;
        tick();
        call = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++; if (pc !== 11'h155 || halted !== 1'b1) begin n_err++; $display("FAIL pre_reset: got %h/%b want 155/1", pc, halted); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pc !== 11'h010 || halted !== 1'b0 || pc_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got pc=%h halted=%b valid=%b want 010/0/0", pc, halted, pc_valid);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        tick();
        ret = 1'b1;
        tick();
        ret = 1'b0;
        n_cmp++; if (pc !== 11'h011 || ras_err !== RAS_ON) begin
            n_err++; $display("FAIL post_reset_ret: got %h/%b want 011/%b", pc, ras_err, RAS_ON);
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(9) != 0);
            halt_req = ($urandom_range(24) == 0);
            resume   = ($urandom_range(3) == 0);
            ret      = ($urandom_range(6) == 0);
            call     = ($urandom_range(6) == 0);
            jmp      = ($urandom_range(5) == 0);
            br       = ($urandom_range(3) == 0);
            jmp_addr = 11'($urandom);
            br_off   = 11'($urandom);
            tick();
            n_cmp++; if (pc !== 11'(m_pc)) begin n_err++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc, 11'(m_pc)); end
            n_cmp++; if (pc_valid !== (!m_boot && !m_halt) || halted !== m_halt) begin
                n_err++; $display("FAIL rand_flags[%0d]: got valid=%b halted=%b want %b/%b", i, pc_valid, halted, (!m_boot && !m_halt), m_halt);
            end
            n_cmp++; if (ras_err !== m_err) begin n_err++; $display("FAIL rand_err[%0d]: got %b want %b", i, ras_err, m_err); end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap_branch();
        test_priority_stall();
        test_halt();
        test_ras();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
